// File: rtl/counter_wait_rx_if.sv
// Output record stream of the counter-pair receive monitor.
// Valid/ready handshake carrying {err, w, b, a} records.
interface counter_wait_rx_if #(
    parameter int DW = 4
);
    logic            out_valid;
    logic            out_ready;
    logic [3*DW:0]   out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/counter_wait_rx.sv
// Receive-side rendezvous monitor for the a/b/W counter pair.
// Optional COUNTER_WAIT_RX_STATS_EN builds the rendezvous counter.
module counter_wait_rx #(
    parameter int DW       = 4,
    parameter int HOLD_CYC = 2,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DW-1:0]       a_in,
    input  logic [DW-1:0]       b_in,
    input  logic [DW-1:0]       w_in,
    counter_wait_rx_if.master   rx,
    output logic                overflow,
    output logic [7:0]          err_cnt,
    output logic [15:0]         rdv_cnt
);
    localparam int RW = 3*DW + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYC - 1);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   stall_cnt, stall_cnt_n;
    logic [DW-1:0]   a_q, b_q;
    logic            stable;
    logic            push;
    logic [DW-1:0]   sum;
    logic            err;
    logic [RW-1:0]   rec;

    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     fill;
    logic            full;
    logic            pop;
    logic            acc;

    assign stable = (a_in == a_q) && (b_in == b_q);
    assign sum    = a_in + b_in;
    assign err    = (w_in != sum);
    assign rec    = {err, w_in, b_in, a_in};

    // Previous-cycle counter values for the stability compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

    // Rendezvous FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            stall_cnt <= stall_cnt_n;
        end
    end

    // Next state; one push per rendezvous on the last stable cycle
    always_comb begin
        state_n     = state;
        stall_cnt_n = stall_cnt;
        push        = 1'b0;
        unique case (state)
            RUN: begin
                if (stable) begin
                    if (HOLD_CYC == 1) begin
                        push        = 1'b1;
                        state_n     = HOLD;
                        stall_cnt_n = '0;
                    end else begin
                        stall_cnt_n = CW'(1);
                        state_n     = STALL;
                    end
                end else begin
                    stall_cnt_n = '0;
                end
            end
            STALL: begin
                if (!stable) begin
                    state_n     = RUN;
                    stall_cnt_n = '0;
                end else if (stall_cnt == LAST) begin
                    push    = 1'b1;
                    state_n = HOLD;
                end else begin
                    stall_cnt_n = stall_cnt + CW'(1);
                end
            end
            HOLD: begin
                if (!stable) begin
                    state_n     = RUN;
                    stall_cnt_n = '0;
                end
            end
            default: begin
                state_n     = RUN;
                stall_cnt_n = '0;
            end
        endcase
    end

    assign full = (fill == FULL);
    assign pop  = rx.out_valid && rx.out_ready;
    assign acc  = push && (!full || pop);

    assign rx.out_valid = (fill != '0);
    assign rx.out_data  = mem[rp];

    // Record FIFO; a full FIFO still accepts when the head leaves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp   <= '0;
            rp   <= '0;
            fill <= '0;
        end else begin
            if (acc) begin
                mem[wp] <= rec;
                wp      <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            unique case ({acc, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Sticky drop flag and saturating mismatch count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (push && err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

`ifdef COUNTER_WAIT_RX_STATS_EN
    // Rendezvous count, dropped records included, wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv_cnt <= '0;
        end else if (push) begin
            rdv_cnt <= rdv_cnt + 16'd1;
        end
    end
`else
    assign rdv_cnt = '0;
`endif

endmodule

// File: tb/tb_counter_wait_rx.sv
// Bench for counter_wait_rx: directed scenarios plus random traffic
// checked every cycle against a run-length/queue model.
module tb_counter_wait_rx;
    localparam int DW = 4;
    localparam int H  = 2;
    localparam int D  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic [3:0]  w = '0;
    logic        overflow;
    logic [7:0]  err_cnt;
    logic [15:0] rdv_cnt;

    counter_wait_rx_if #(.DW(DW)) ifc ();

    counter_wait_rx #(
        .DW(DW),
        .HOLD_CYC(H),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .a_in(a),
        .b_in(b),
        .w_in(w),
        .rx(ifc),
        .overflow(overflow),
        .err_cnt(err_cnt),
        .rdv_cnt(rdv_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int hs   = 0;

    logic [12:0] q[$];
    int          pa, pb, run;
    bit          movf;
    int          merr, mrdv;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pa = 0; pb = 0; run = 0;
        movf = 0; merr = 0; mrdv = 0;
    endtask

    task automatic compare();
        chk("out_valid", 32'(ifc.out_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            chk("out_data", 32'(ifc.out_data), 32'(q[0]));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("err_cnt", 32'(err_cnt), 32'(merr));
        chk("rdv_cnt", 32'(rdv_cnt), 32'(mrdv));
    endtask

    task automatic mstep(int ai, int bi, int wi, bit r);
        bit st, push, pop, full, e;
        st   = (ai == pa) && (bi == pb);
        run  = st ? run + 1 : 0;
        push = (run == H);
        full = (q.size() == D);
        pop  = (q.size() != 0) && r;
        e    = (wi != ((ai + bi) % 16));
        if (pop) void'(q.pop_front());
        if (push) begin
            if (!full || pop)
                q.push_back({e, 4'(wi), 4'(bi), 4'(ai)});
            else
                movf = 1;
            if (e && merr < 255) merr++;
`ifdef COUNTER_WAIT_RX_STATS_EN
            mrdv = (mrdv + 1) % 65536;
`endif
        end
        pa = ai;
        pb = bi;
    endtask

    task automatic cyc(int ai, int bi, int wi, bit r);
        @(negedge clk);
        compare();
        a = 4'(ai);
        b = 4'(bi);
        w = 4'(wi);
        ifc.out_ready = r;
        if (ifc.out_valid && r) hs++;
        mstep(ai, bi, wi, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_data", 32'(ifc.out_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_rdv", 32'(rdv_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int hs0, ai, bi, wi;
        bit r;
        ifc.out_ready = 1'b0;
        model_reset();
        do_reset();

        // 1: clean rendezvous
        cyc(0, 0, 5, 1);
        cyc(1, 1, 5, 1);
        cyc(2, 2, 5, 1);
        cyc(2, 3, 5, 1);
        cyc(2, 3, 5, 1);
        cyc(2, 3, 5, 1);
        chk("s1_valid", 32'(ifc.out_valid), 32'd1);
        chk("s1_data", 32'(ifc.out_data), 32'h0532);
        cyc(2, 3, 5, 1);
        chk("s1_onecyc", 32'(ifc.out_valid), 32'd0);
        chk("s1_err", 32'(err_cnt), 32'd0);

        // 2: mismatching W
        cyc(4, 4, 7, 1);
        cyc(4, 4, 7, 1);
        cyc(4, 4, 7, 1);
        chk("s2_data", 32'(ifc.out_data), 32'h1744);
        chk("s2_err", 32'(err_cnt), 32'd1);

        // 3: sum wraps
        cyc(9, 9, 2, 1);
        cyc(9, 9, 2, 1);
        cyc(9, 9, 2, 1);
        chk("s3_data", 32'(ifc.out_data), 32'h0299);
        chk("s3_err", 32'(err_cnt), 32'd1);
        cyc(9, 9, 2, 1);

        // 4: overflow with consumer stalled
        for (int k = 1; k <= 3; k++)
            for (int j = 0; j < 3; j++)
                cyc(k, k, 2 * k, 0);
        chk("s4_ovf", 32'(overflow), 32'd1);
        chk("s4_head", 32'(ifc.out_data), 32'h0211);
        cyc(3, 3, 6, 1);
        chk("s4_next", 32'(ifc.out_data), 32'h0422);
        cyc(3, 3, 6, 1);
        chk("s4_empty", 32'(ifc.out_valid), 32'd0);

        // 5: long hold gives one record
        hs0 = hs;
        for (int j = 0; j < 11; j++) cyc(5, 6, 11, 1);
        chk("s5_one", 32'(hs - hs0), 32'd1);
        cyc(5, 7, 12, 1);
        cyc(5, 7, 12, 1);
        cyc(5, 7, 12, 1);
        cyc(5, 7, 12, 1);
        chk("s5_two", 32'(hs - hs0), 32'd2);

        // 6: reset mid-STALL with a queued record
        cyc(8, 1, 9, 0);
        cyc(8, 1, 9, 0);
        cyc(8, 1, 9, 0);
        cyc(6, 6, 12, 0);
        cyc(6, 6, 12, 0);
        do_reset();
        cyc(6, 6, 12, 1);
        cyc(6, 6, 12, 1);
        chk("s6_none", 32'(ifc.out_valid), 32'd0);
        cyc(6, 6, 12, 1);
        chk("s6_rec", 32'(ifc.out_data), 32'h0C66);

        // Random traffic
        ai = 6; bi = 6;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(3) == 0) ai = $urandom_range(15);
            if ($urandom_range(3) == 0) bi = $urandom_range(15);
            wi = ($urandom_range(1) == 0) ? (ai + bi) % 16
                                           : $urandom_range(15);
            r  = ($urandom_range(2) != 0);
            cyc(ai, bi, wi, r);
        end
        @(negedge clk);
        compare();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
